// File: rtl/cpu_flow_ctrl_pkg.sv
// CPU-wide shared constants and the flow-control request type.
package cpu_flow_ctrl_pkg;

  // Shared with the program counter and instruction memory.
  localparam int unsigned CPU_WIDTH     = 8;
  localparam int unsigned CPU_RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_JMP,
    REQ_CALL,
    REQ_RET
  } flow_req_e;

endpackage

// File: rtl/cpu_flow_ctrl_ras_mem.sv
// Return-address storage: DEPTH x WIDTH registers, one synchronous write port,
// one combinational read port. Contents are never reset.
module cpu_ras_mem
  import cpu_flow_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned DEPTH = CPU_RAS_DEPTH
) (
  input  logic                       CLK,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_flow_ctrl.sv
// Jump/call/return flow control with a return-address stack; drives the
// program-counter load strobe and address combinationally.
module cpu_flow_ctrl
  import cpu_flow_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned DEPTH = CPU_RAS_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         PC,
  input  logic                     JMP,
  input  logic                     CALL,
  input  logic                     RET,
  input  logic [WIDTH-1:0]         TARGET,
  input  logic                     CLR_ERR,
  output logic                     PC_LD,
  output logic [WIDTH-1:0]         PC_ADDR,
  output logic [$clog2(DEPTH):0]   SP,
  output logic                     STK_FULL,
  output logic                     STK_EMPTY,
  output logic                     OVF,
  output logic                     UNF
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = AW + 1;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  flow_req_e      req;
  logic [SPW-1:0] sp_q = '0;
  logic [SPW-1:0] sp_d;
  logic           ovf_q = 1'b0;
  logic           ovf_d;
  logic           unf_q = 1'b0;
  logic           unf_d;
  logic           full;
  logic           empty;
  logic           push;
  logic [AW-1:0]  rd_ptr;
  logic [WIDTH-1:0] tos;

  assign full   = (sp_q == SP_MAX);
  assign empty  = (sp_q == '0);
  assign push   = (req == REQ_CALL) && !full;
  // Wraps to the last slot when empty; never used then.
  assign rd_ptr = AW'(sp_q - SPW'(1));

  always_comb begin
    req = REQ_NONE;
    if (RST)       req = REQ_NONE;
    else if (CALL) req = REQ_CALL;
    else if (RET)  req = REQ_RET;
    else if (JMP)  req = REQ_JMP;
  end

  cpu_ras_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras_mem (
    .CLK     (CLK),
    .we_i    (push),
    .waddr_i (sp_q[AW-1:0]),
    .wdata_i (PC + WIDTH'(1)),
    .raddr_i (rd_ptr),
    .rdata_o (tos)
  );

  always_comb begin
    PC_LD   = 1'b0;
    PC_ADDR = '0;
    case (req)
      REQ_CALL, REQ_JMP: begin
        PC_LD   = 1'b1;
        PC_ADDR = TARGET;
      end
      REQ_RET: begin
        if (!empty) begin
          PC_LD   = 1'b1;
          PC_ADDR = tos;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    sp_d = sp_q;
    if (push)                             sp_d = sp_q + SPW'(1);
    else if ((req == REQ_RET) && !empty)  sp_d = sp_q - SPW'(1);
    // A new error event outranks a simultaneous clear.
    ovf_d = ((req == REQ_CALL) && full) | (ovf_q & ~CLR_ERR);
    unf_d = ((req == REQ_RET) && empty) | (unf_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign SP        = sp_q;
  assign STK_FULL  = full;
  assign STK_EMPTY = empty;
  assign OVF       = ovf_q;
  assign UNF       = unf_q;

endmodule

// File: tb/tb_cpu_flow_ctrl.sv
// Self-checking bench for cpu_flow_ctrl: directed scenarios plus random
// traffic against a queue-based return-stack model.
module tb_cpu_flow_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] PC = '0;
  logic             JMP = 1'b0;
  logic             CALL = 1'b0;
  logic             RET = 1'b0;
  logic [WIDTH-1:0] TARGET = '0;
  logic             CLR_ERR = 1'b0;
  logic             PC_LD;
  logic [WIDTH-1:0] PC_ADDR;
  logic [3:0]       SP;
  logic             STK_FULL;
  logic             STK_EMPTY;
  logic             OVF;
  logic             UNF;

  cpu_flow_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PC        (PC),
    .JMP       (JMP),
    .CALL      (CALL),
    .RET       (RET),
    .TARGET    (TARGET),
    .CLR_ERR   (CLR_ERR),
    .PC_LD     (PC_LD),
    .PC_ADDR   (PC_ADDR),
    .SP        (SP),
    .STK_FULL  (STK_FULL),
    .STK_EMPTY (STK_EMPTY),
    .OVF       (OVF),
    .UNF       (UNF)
  );

  always #5 CLK = ~CLK;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [WIDTH-1:0] m_stk[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input bit rst, input bit call, input bit ret, input bit jmp,
                       input bit clr, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] tgt);
    RST = rst; CALL = call; RET = ret; JMP = jmp; CLR_ERR = clr; PC = pc; TARGET = tgt;
  endtask

  // Check outputs mid-cycle against the model, then advance the model on the edge.
  task automatic step(input string tag, output logic ld_o, output logic [WIDTH-1:0] addr_o);
    bit               full, empty, exp_ld, new_ovf, new_unf;
    logic [WIDTH-1:0] exp_addr;
    logic [WIDTH-1:0] ret_addr;
    @(negedge CLK);
    full  = (m_stk.size() == DEPTH);
    empty = (m_stk.size() == 0);
    exp_ld = 1'b0; exp_addr = '0;
    if (RST) begin
      exp_ld = 1'b0;
    end else if (CALL || (!RET && JMP)) begin
      exp_ld = 1'b1; exp_addr = TARGET;
    end else if (RET && !empty) begin
      exp_ld = 1'b1; exp_addr = m_stk[m_stk.size()-1];
    end
    chk({tag, "_ld"},    32'(PC_LD),     32'(exp_ld));
    chk({tag, "_addr"},  32'(PC_ADDR),   32'(exp_addr));
    chk({tag, "_sp"},    32'(SP),        m_stk.size());
    chk({tag, "_full"},  32'(STK_FULL),  32'(full));
    chk({tag, "_empty"}, 32'(STK_EMPTY), 32'(empty));
    chk({tag, "_ovf"},   32'(OVF),       32'(m_ovf));
    chk({tag, "_unf"},   32'(UNF),       32'(m_unf));
    ld_o = PC_LD; addr_o = PC_ADDR;
    @(posedge CLK);
    if (RST) begin
      m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      new_ovf = CALL && full;
      new_unf = !CALL && RET && empty;
      m_ovf = new_ovf || (m_ovf && !CLR_ERR);
      m_unf = new_unf || (m_unf && !CLR_ERR);
      if (CALL) begin
        if (!full) m_stk.push_back(PC + 8'd1);
      end else if (RET && !empty) begin
        ret_addr = m_stk.pop_back();
      end
    end
    #1;
  endtask

  logic             ld;
  logic [WIDTH-1:0] addr;

  initial begin
    // Power-up state before any reset.
    @(negedge CLK);
    chk("pwr_sp", 32'(SP), 0);
    chk("pwr_ovf", 32'(OVF), 0);
    chk("pwr_unf", 32'(UNF), 0);
    @(posedge CLK); #1;

    drive(1, 0, 0, 0, 0, 8'h00, 8'h00); step("rst", ld, addr);
    chk("rst_sp", 32'(SP), 0);

    // Jump.
    drive(0, 0, 0, 1, 0, 8'h05, 8'h40); step("jmp", ld, addr);
    chk("jmp_ld", 32'(ld), 1); chk("jmp_addr", 32'(addr), 32'h40); chk("jmp_sp", 32'(SP), 0);

    // Nested call/return.
    drive(0, 1, 0, 0, 0, 8'h10, 8'h80); step("c1", ld, addr);
    chk("c1_addr", 32'(addr), 32'h80); chk("c1_sp", 32'(SP), 1);
    drive(0, 1, 0, 0, 0, 8'h85, 8'hA0); step("c2", ld, addr);
    chk("c2_addr", 32'(addr), 32'hA0); chk("c2_sp", 32'(SP), 2);
    drive(0, 0, 1, 0, 0, 8'hA0, 8'h00); step("r1", ld, addr);
    chk("r1_addr", 32'(addr), 32'h86); chk("r1_sp", 32'(SP), 1);
    drive(0, 0, 1, 0, 0, 8'h86, 8'h00); step("r2", ld, addr);
    chk("r2_addr", 32'(addr), 32'h11); chk("r2_sp", 32'(SP), 0);

    // Overflow.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 0, 8'(i * 3), 8'(8'h50 + i)); step("fill", ld, addr);
    end
    chk("fill_full", 32'(STK_FULL), 1);
    drive(0, 1, 0, 0, 0, 8'h77, 8'h33); step("ovf", ld, addr);
    chk("ovf_ld", 32'(ld), 1); chk("ovf_addr", 32'(addr), 32'h33);
    chk("ovf_sp", 32'(SP), 8); chk("ovf_flag", 32'(OVF), 1);
    drive(0, 0, 0, 0, 1, 8'h00, 8'h00); step("clr", ld, addr);
    chk("clr_ovf", 32'(OVF), 0);
    // Error event beats a simultaneous clear.
    drive(0, 1, 0, 0, 1, 8'h01, 8'h02); step("ovfclr", ld, addr);
    chk("ovfclr_flag", 32'(OVF), 1);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00); step("ret_top", ld, addr);
    chk("ret_top_addr", 32'(addr), 32'h16);

    // Underflow.
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00); step("rst2", ld, addr);
    drive(0, 0, 1, 0, 0, 8'h30, 8'h44); step("unf", ld, addr);
    chk("unf_ld", 32'(ld), 0); chk("unf_addr", 32'(addr), 0);
    chk("unf_flag", 32'(UNF), 1); chk("unf_sp", 32'(SP), 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 8'h31, 8'h00); step("idle", ld, addr);
    end
    chk("unf_hold", 32'(UNF), 1);

    // Priority and PC+1 wrap.
    drive(0, 1, 1, 1, 0, 8'hFF, 8'h20); step("prio", ld, addr);
    chk("prio_addr", 32'(addr), 32'h20); chk("prio_sp", 32'(SP), 1);
    drive(0, 0, 1, 1, 0, 8'h20, 8'h99); step("wrap", ld, addr);
    chk("wrap_addr", 32'(addr), 32'h00);

    // Reset beats a call.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 8'(i), 8'h60); step("pre", ld, addr);
    end
    chk("pre_sp", 32'(SP), 3);
    drive(1, 1, 0, 0, 0, 8'h12, 8'h34); step("rstcall", ld, addr);
    chk("rstcall_ld", 32'(ld), 0); chk("rstcall_sp", 32'(SP), 0);
    chk("rstcall_ovf", 32'(OVF), 0); chk("rstcall_unf", 32'(UNF), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            8'($urandom), 8'($urandom));
      step("rnd", ld, addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_flow_ctrl.md
CPU_FLOW_CTRL -- requirements
Module: cpu_flow_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, address width; matches the program counter width.
REQ-002 Parameter DEPTH, default 8, return-stack entries; power of two, >= 2.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 PC  input  WIDTH  current program counter value.
REQ-006 JMP  input  1  unconditional jump request to TARGET, this cycle.
REQ-007 CALL  input  1  subroutine call to TARGET; pushes return address.
REQ-008 RET  input  1  return; pops the return address.
REQ-009 TARGET  input  WIDTH  jump/call destination.
REQ-010 CLR_ERR  input  1  clears sticky error flags.
REQ-011 PC_LD  output  1  load strobe to the program counter (combinational).
REQ-012 PC_ADDR  output  WIDTH  load address to the program counter (combinational).
REQ-013 SP  output  clog2(DEPTH)+1  number of valid stack entries.
REQ-014 STK_FULL / STK_EMPTY  output  1 each  SP==DEPTH / SP==0.
REQ-015 OVF / UNF  output  1 each  sticky overflow / underflow flags.

Function
REQ-016 Priority when several requests are asserted together: CALL > RET > JMP; lower-priority requests are ignored that cycle.
REQ-017 JMP (effective): PC_LD=1 and PC_ADDR=TARGET in the same cycle; stack unchanged.
REQ-018 CALL, not full: PC_LD=1, PC_ADDR=TARGET; on the edge push PC+1 (modulo 2^WIDTH) and SP increments.
REQ-019 CALL while full: PC_LD=1, PC_ADDR=TARGET; push dropped; SP and stack contents unchanged; OVF set on the edge.
REQ-020 RET, not empty: PC_LD=1, PC_ADDR=top-of-stack; on the edge SP decrements.
REQ-021 RET while empty: PC_LD=0 (PC increments normally); PC_ADDR=0; UNF set on the edge.
REQ-022 No effective request: PC_LD=0 and PC_ADDR=0.
REQ-023 PC_LD and PC_ADDR are purely combinational from inputs and state, giving zero-cycle latency for the single-cycle CPU; no registered path on this output.
REQ-024 Back-to-back CALL/RET on consecutive cycles are supported without bubbles; each RET sees the entry pushed by the most recent un-popped CALL.
REQ-025 OVF/UNF stay set until RST or CLR_ERR; if CLR_ERR coincides with a new error event, the flag remains set.
REQ-026 Stack entries above SP are don't-care and never observable at PC_ADDR.

Reset
REQ-027 RST has priority over all requests; on the reset edge SP=0, OVF=0, UNF=0; storage contents are not cleared.
REQ-028 While RST=1, PC_LD=0 and PC_ADDR=0 regardless of requests.
REQ-029 Power-up initial values: SP=0, OVF=0, UNF=0.

Structure
REQ-030 Default WIDTH and DEPTH are shared constants in the CPU-wide parameter package, common with the program counter and instruction memory.
REQ-031 Storage is one sub-module, cpu_ras_mem: DEPTH x WIDTH register array with one synchronous write port and one combinational read port; SP logic, priority and error flags stay in cpu_flow_ctrl.

Verification
REQ-032 Reset, then JMP=1, TARGET=0x40 -> PC_LD=1, PC_ADDR=0x40 in the same cycle; SP remains 0.
REQ-033 PC=0x10 with CALL to 0x80, then PC=0x85 with CALL to 0xA0, then RET, then RET -> PC_ADDR sequence 0x80, 0xA0, 0x86, 0x11; SP sequence 1, 2, 1, 0.
REQ-034 Eight CALLs, then a ninth CALL to 0x33 -> PC_ADDR=0x33, PC_LD=1, SP stays 8, OVF=1; CLR_ERR clears OVF.
REQ-035 RET with SP=0 -> PC_LD=0, UNF=1, SP stays 0; UNF persists across 5 idle cycles.
REQ-036 CALL+RET+JMP asserted together with PC=0xFF and TARGET=0x20 -> CALL wins; pushed value is 0x00 (wrap).
REQ-037 RST asserted in the same cycle as CALL with SP=3 -> PC_LD=0, next SP=0, flags 0.
